mux_arb_nx1: RTL and testbench
==============================

// Module: mux_arb_nx1
// PURPOSE
//  Parametrised N-to-1 registered multiplexer. It generalises the 3x1 select mux
//  to any WIDTH and channel count, with per-channel valid/ready handshakes.
//  Two modes: explicit ctrl select, or round-robin arbitration among valid inputs.
//  Sits between multiple producers and one consumer stage. Output is registered,
//  with one-cycle latency and full throughput.
// PARAMETERS
//  WIDTH   8  data bits per channel
//  N       3  number of input channels (>=2)
//  MODE    0  0 = ctrl-select, 1 = round-robin arbitration (ctrl ignored)
//  CTRL_W  $clog2(N)  derived; width of ctrl/out_src (localparam, not overridable)
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         asynchronous, active-high reset
//  in_data    in   N*WIDTH   channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N         channel i has a word
//  in_ready   out  N         channel i word accepted this cycle
//  ctrl       in   CTRL_W    selected channel (MODE 0 only)
//  out        out  WIDTH     held output word
//  out_valid  out  1         out holds a word
//  out_ready  in   1         consumer accepts out this cycle
//  out_src    out  CTRL_W    channel index that produced out
// BEHAVIOUR
//  - Clock, reset, and reset values:
//    - One clock; reset is asynchronous and active-high.
//    - While reset=1: out=0, out_valid=0, out_src=0, rr_ptr=0.
//    - in_ready is combinational and therefore 0 while out_valid=0 is forced
//      and no channel is valid.
//  - Storage and states:
//    - The output register holds one word: EMPTY (out_valid=0) or FULL (out_valid=1).
//    - load_en = !out_valid | out_ready.
//  - Channel selection (sel):
//    - MODE 0: sel=ctrl. hit = (ctrl<N) & in_valid[ctrl].
//    - ctrl>=N: no channel is selected, all in_ready=0, and nothing loads.
//    - MODE 1: sel = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ...
//      modulo N. hit = |in_valid.
//  - in_ready and transfer rules:
//    - in_ready[i] = load_en & hit & (i==sel). At most one bit is ever set.
//    - in_ready is combinational from in_valid/ctrl/out_valid/out_ready/rr_ptr.
//    - Transfer on channel i occurs when in_valid[i] & in_ready[i].
//  - Next state, at the clock edge:
//    - load_en & hit: out<=in_data[sel], out_src<=sel, out_valid<=1.
//    - load_en & !hit: out_valid<=0. out and out_src keep their old values.
//    - !load_en: all state holds. A FULL register is never overwritten.
//  - rr_ptr (MODE 1 only):
//    - On each transfer, rr_ptr <= (sel==N-1) ? 0 : sel+1.
//    - Otherwise it holds, so each valid channel is granted within N transfers.
//  - Latency and throughput:
//    - A word accepted at edge k appears on out with out_valid=1 after edge k.
//    - Drain and reload in the same cycle (FULL & out_ready & hit) sustains
//      1 word/cycle.
//  - Input stability:
//    - Changing ctrl while FULL does not alter the held out or out_src.
//    - A producer may deassert in_valid without a transfer; no word is lost,
//      because nothing is latched without in_ready.
//  - Reset mid-operation: a held word is discarded. rr_ptr returns to 0, and the
//    next grant scans from channel 0.
//  - Width rules: no arithmetic on data. rr_ptr wrap is explicit, not a modulo
//    2^CTRL_W, so non-power-of-2 N is correct.
// TESTING
//  - T1, reset: assert reset async mid-cycle with out_valid=1.
//    -> out=0, out_valid=0, out_src=0 immediately; no in_ready while empty and
//    nothing valid.
//  - T2, MODE0 select, N=3, WIDTH=8, out_ready=1:
//    - ctrl=0,1,2 with in_data={8'h33,8'h22,8'h11} and all valid
//      -> out=11,22,33 with out_src=0,1,2, each one cycle after select.
//    - ctrl=3 -> out_valid=0, in_ready=000.
//  - T3, backpressure (MODE0): load 8'hA5, then out_ready=0 for 4 cycles while
//    ctrl and in_data change.
//    -> out stays A5, in_ready=000. Then out_ready=1 -> next word loads the same
//    cycle A5 drains.
//  - T4, round-robin (MODE1, N=3): all in_valid=1 and out_ready=1 for 6 cycles
//    -> out_src sequence 0,1,2,0,1,2.
//  - T5, round-robin skip: in_valid=3'b101 and rr_ptr=1
//    -> grant ch2, then ch0, then ch2. With in_valid=0 -> out_valid drops to 0
//    after the drain.
//  - T6, N=5 wrap: MODE1, only ch4 and ch0 valid
//    -> out_src alternates 4,0,4,0. rr_ptr never takes a value >=5.

Source files
------------

// File: rtl/mux_arb_nx1_if.sv
// Handshake bundle between N producers, the N-to-1 mux and its single consumer.
// The mux sits on the slave modport; the surrounding producers/consumer drive the master side.
interface mux_arb_nx1_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 3
);
  localparam int unsigned CTRL_W = (N > 1) ? $clog2(N) : 1;

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [CTRL_W-1:0]  ctrl;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic               out_ready;
  logic [CTRL_W-1:0]  out_src;

  modport master (
    output in_data, in_valid, ctrl, out_ready,
    input  in_ready, out, out_valid, out_src
  );

  modport slave (
    input  in_data, in_valid, ctrl, out_ready,
    output in_ready, out, out_valid, out_src
  );
endinterface

// File: rtl/mux_arb_nx1.sv
// Registered N-to-1 mux with per-channel valid/ready handshakes.
// MODE 0 selects the channel named by ctrl; MODE 1 arbitrates round-robin among valid inputs.
module mux_arb_nx1 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 3,
  parameter int unsigned MODE  = 0
) (
  input logic          clk,
  input logic          reset,
  mux_arb_nx1_if.slave bus
);
  localparam int unsigned CTRL_W = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0]  out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] out_src_q, out_src_d;
  logic [CTRL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic              load_en;
  logic              hit;
  logic [CTRL_W-1:0] sel;
  logic [WIDTH-1:0]  sel_data;
  logic [N-1:0]      in_ready_c;

  // A FULL register may only be replaced when the consumer takes it this cycle.
  assign load_en = ~out_valid_q | bus.out_ready;

  always_comb begin
    hit = 1'b0;
    sel = '0;
    if (MODE == 0) begin
      // ctrl values >= N match no channel, so hit stays low and nothing loads.
      for (int i = 0; i < N; i++) begin
        if (bus.ctrl == CTRL_W'(i)) begin
          hit = bus.in_valid[i];
          sel = CTRL_W'(i);
        end
      end
    end else begin
      // Rotating priority without modulo: channels at/above rr_ptr first, then the wrap.
      for (int i = 0; i < N; i++) begin
        if (!hit && bus.in_valid[i] && (CTRL_W'(i) >= rr_ptr_q)) begin
          hit = 1'b1;
          sel = CTRL_W'(i);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!hit && bus.in_valid[i] && (CTRL_W'(i) < rr_ptr_q)) begin
          hit = 1'b1;
          sel = CTRL_W'(i);
        end
      end
    end
  end

  always_comb begin
    sel_data   = '0;
    in_ready_c = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == CTRL_W'(i)) begin
        sel_data      = bus.in_data[i*WIDTH +: WIDTH];
        in_ready_c[i] = load_en & hit;
      end
    end
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      if (hit) begin
        out_d       = sel_data;
        out_src_d   = sel;
        out_valid_d = 1'b1;
        if (MODE == 1) begin
          rr_ptr_d = (sel == CTRL_W'(N - 1)) ? '0 : sel + CTRL_W'(1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_src   = out_src_q;
  assign bus.in_ready  = in_ready_c;
endmodule

// File: tb/tb_mux_arb_nx1.sv
// Bench for mux_arb_nx1: three instances (ctrl-select N=3, round-robin N=3, round-robin N=5)
// checked every cycle against a behavioural model, plus literal expectations per scenario.
module tb_mux_arb_nx1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mux_arb_nx1_if #(.WIDTH(8), .N(3)) i0 ();
  mux_arb_nx1_if #(.WIDTH(8), .N(3)) i1 ();
  mux_arb_nx1_if #(.WIDTH(8), .N(5)) i2 ();

  mux_arb_nx1 #(.WIDTH(8), .N(3), .MODE(0)) u0 (.clk(clk), .reset(reset), .bus(i0));
  mux_arb_nx1 #(.WIDTH(8), .N(3), .MODE(1)) u1 (.clk(clk), .reset(reset), .bus(i1));
  mux_arb_nx1 #(.WIDTH(8), .N(5), .MODE(1)) u2 (.clk(clk), .reset(reset), .bus(i2));

  int total = 0;
  int bad = 0;

  // Uniform views of the three instances, zero-extended to the widest (N=5).
  logic [4:0]  v_a[3];
  logic [39:0] d_a[3];
  int          c_a[3];
  logic        r_a[3];
  logic [7:0]  o_a[3];
  logic        ov_a[3];
  int          os_a[3];
  logic [4:0]  ir_a[3];

  always_comb begin
    v_a[0] = {2'b0, i0.in_valid};  v_a[1] = {2'b0, i1.in_valid};  v_a[2] = i2.in_valid;
    d_a[0] = {16'b0, i0.in_data};  d_a[1] = {16'b0, i1.in_data};  d_a[2] = i2.in_data;
    c_a[0] = int'(i0.ctrl);        c_a[1] = int'(i1.ctrl);        c_a[2] = int'(i2.ctrl);
    r_a[0] = i0.out_ready;         r_a[1] = i1.out_ready;         r_a[2] = i2.out_ready;
    o_a[0] = i0.out;               o_a[1] = i1.out;               o_a[2] = i2.out;
    ov_a[0] = i0.out_valid;        ov_a[1] = i1.out_valid;        ov_a[2] = i2.out_valid;
    os_a[0] = int'(i0.out_src);    os_a[1] = int'(i1.out_src);    os_a[2] = int'(i2.out_src);
    ir_a[0] = {2'b0, i0.in_ready}; ir_a[1] = {2'b0, i1.in_ready}; ir_a[2] = i2.in_ready;
  end

  function automatic int n_of(input int k);
    return (k == 2) ? 5 : 3;
  endfunction

  function automatic int mode_of(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  // Selection rule: explicit ctrl, or the first valid channel counting up from ptr modulo n.
  function automatic void pick(input int mode, input int n, input logic [4:0] v, input int ctrl,
                               input int ptr, output bit hit, output int sel);
    int c;
    hit = 1'b0;
    sel = 0;
    if (mode == 0) begin
      if (ctrl < n && v[ctrl]) begin
        hit = 1'b1;
        sel = ctrl;
      end
    end else begin
      for (int j = 0; j < n; j++) begin
        c = (ptr + j) % n;
        if (!hit && v[c]) begin
          hit = 1'b1;
          sel = c;
        end
      end
    end
  endfunction

  int   m_out[3] = '{0, 0, 0};
  bit   m_vld[3] = '{0, 0, 0};
  int   m_src[3] = '{0, 0, 0};
  int   m_ptr[3] = '{0, 0, 0};

  bit m_hit;
  int m_sel;
  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_out[k] <= 0;
        m_vld[k] <= 1'b0;
        m_src[k] <= 0;
        m_ptr[k] <= 0;
      end else if (!m_vld[k] || r_a[k]) begin
        pick(mode_of(k), n_of(k), v_a[k], c_a[k], m_ptr[k], m_hit, m_sel);
        if (m_hit) begin
          m_out[k] <= int'(d_a[k][m_sel*8 +: 8]);
          m_src[k] <= m_sel;
          m_vld[k] <= 1'b1;
          if (mode_of(k) == 1) m_ptr[k] <= (m_sel + 1) % n_of(k);
        end else begin
          m_vld[k] <= 1'b0;
        end
      end
    end
  end

  task automatic check(input int k, input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL dut%0d %s: got %0h want %0h at %0t", k, nm, act, exp, $time);
    end
  endtask

  bit c_hit;
  int c_sel;
  int exp_ir;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      pick(mode_of(k), n_of(k), v_a[k], c_a[k], m_ptr[k], c_hit, c_sel);
      exp_ir = ((!m_vld[k] || r_a[k]) && c_hit) ? (1 << c_sel) : 0;
      check(k, "model out", int'(o_a[k]), m_out[k]);
      check(k, "model out_valid", int'(ov_a[k]), int'(m_vld[k]));
      check(k, "model out_src", os_a[k], m_src[k]);
      check(k, "model in_ready", int'(ir_a[k]), exp_ir);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rr_dat[3];

  initial begin
    i0.in_data = '0; i0.in_valid = '0; i0.ctrl = '0; i0.out_ready = 1'b0;
    i1.in_data = '0; i1.in_valid = '0; i1.ctrl = '0; i1.out_ready = 1'b0;
    i2.in_data = '0; i2.in_valid = '0; i2.ctrl = '0; i2.out_ready = 1'b0;
    #1 reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Fill dut0 and hold it (no consumer), then assert reset asynchronously mid-cycle.
    i0.in_data = {8'h00, 8'h00, 8'h77};
    i0.in_valid = 3'b001;
    step();
    i0.in_valid = 3'b000;
    check(0, "pre-reset out_valid", int'(i0.out_valid), 1);
    check(0, "pre-reset out", int'(i0.out), 'h77);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check(0, "reset out", int'(i0.out), 0);
    check(0, "reset out_valid", int'(i0.out_valid), 0);
    check(0, "reset out_src", int'(i0.out_src), 0);
    check(0, "reset in_ready", int'(i0.in_ready), 0);
    step();
    reset = 1'b0;

    // Explicit select, consumer always ready.
    i0.in_data = {8'h33, 8'h22, 8'h11};
    i0.in_valid = 3'b111;
    i0.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      i0.ctrl = 2'(j);
      step();
      check(0, "sel out_src", int'(i0.out_src), j);
      check(0, "sel out", int'(i0.out), 'h11 * (j + 1));
    end
    i0.ctrl = 2'd3;
    #1 check(0, "ctrl3 in_ready", int'(i0.in_ready), 0);
    step();
    check(0, "ctrl3 out_valid", int'(i0.out_valid), 0);

    // Backpressure: held word survives ctrl/data churn, then drain+reload in one edge.
    i0.ctrl = 2'd0;
    i0.in_data = {8'h33, 8'h22, 8'hA5};
    step();
    check(0, "bp load", int'(i0.out), 'hA5);
    i0.out_ready = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      i0.ctrl = 2'(j % 3);
      i0.in_data = {8'(j), 8'(j + 8), 8'(j + 16)};
      #1 check(0, "bp in_ready", int'(i0.in_ready), 0);
      step();
      check(0, "bp hold out", int'(i0.out), 'hA5);
      check(0, "bp hold src", int'(i0.out_src), 0);
    end
    i0.out_ready = 1'b1;
    i0.ctrl = 2'd1;
    i0.in_data = {8'h33, 8'h5A, 8'hA5};
    #1 check(0, "reload in_ready", int'(i0.in_ready), 'b010);
    step();
    check(0, "reload out", int'(i0.out), 'h5A);
    check(0, "reload out_valid", int'(i0.out_valid), 1);
    i0.in_valid = 3'b000;
    step();

    // Round-robin with every channel valid.
    rr_dat = '{8'hA1, 8'hB2, 8'hC3};
    i1.in_data = {rr_dat[2], rr_dat[1], rr_dat[0]};
    i1.in_valid = 3'b111;
    i1.out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      check(1, "rr out_src", int'(i1.out_src), j % 3);
      check(1, "rr out", int'(i1.out), int'(rr_dat[j % 3]));
    end

    // Skip over the invalid channel starting from rr_ptr=1.
    i1.in_valid = 3'b001;
    step();
    check(1, "skip prime", int'(i1.out_src), 0);
    i1.in_valid = 3'b101;
    step();
    check(1, "skip 1st", int'(i1.out_src), 2);
    step();
    check(1, "skip 2nd", int'(i1.out_src), 0);
    step();
    check(1, "skip 3rd", int'(i1.out_src), 2);
    i1.in_valid = 3'b000;
    step();
    check(1, "drain out_valid", int'(i1.out_valid), 0);
    check(1, "drain keeps out", int'(i1.out), 'hC3);

    // N=5 wrap: move the pointer to 4, then alternate between the two end channels.
    i2.in_data = {8'hE4, 8'hE3, 8'hE2, 8'hE1, 8'hE0};
    i2.out_ready = 1'b1;
    i2.in_valid = 5'b01000;
    step();
    check(2, "wrap prime", int'(i2.out_src), 3);
    i2.in_valid = 5'b10001;
    for (int j = 0; j < 4; j++) begin
      step();
      check(2, "wrap out_src", int'(i2.out_src), (j % 2 == 0) ? 4 : 0);
      check(2, "wrap out", int'(i2.out), (j % 2 == 0) ? 'hE4 : 'hE0);
    end
    i2.in_valid = 5'b00000;
    step();
    check(2, "wrap drain", int'(i2.out_valid), 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
